seq_div: RTL

Sequential unsigned restoring divider. It is the inverse companion of the shift-add array multiplier in the ALU datapath. The block accepts an N-bit dividend and divisor on a start pulse and resolves one quotient bit per clock, MSB first. It then presents the quotient and remainder with a one-cycle done strobe. It sits beside the multiplier, and the ALU selects its results for divide opcodes.

---
 rtl/seq_div.sv | 77 +++++++
 1 files changed

// File: rtl/seq_div.sv
// seq_div: sequential unsigned restoring divider, one quotient bit per clock, MSB first.
module seq_div #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] q,
    output logic [N-1:0] r,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);
    localparam int CW = $clog2(N + 1);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;
    logic [0:0]    state;
    logic [N-1:0]  dvd;
    logic [N-1:0]  dvs;
    logic [N-1:0]  rem;
    logic [CW-1:0] cnt;
    logic [N:0]    s;
    logic [N:0]    t;
    logic [N-1:0]  rem_nx;
    logic [N-1:0]  dvd_nx;
    // The dividend register doubles as the quotient: bits leave at the MSB and results enter at the LSB.
    // The partial remainder never reaches 2^N because it stays below the divisor, so N bits suffice.
    always_comb begin
        s      = {rem, dvd[N-1]};
        t      = s - {1'b0, dvs};
        rem_nx = t[N] ? s[N-1:0] : t[N-1:0];
        dvd_nx = {dvd[N-2:0], ~t[N]};
    end
    assign busy = state == RUN;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            dvd      <= '0;
            dvs      <= '0;
            rem      <= '0;
            cnt      <= '0;
            q        <= '0;
            r        <= '0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (start && b != '0) begin
                    dvd      <= a;
                    dvs      <= b;
                    rem      <= '0;
                    cnt      <= '0;
                    div_zero <= 1'b0;
                    state    <= RUN;
                end else if (start) begin
                    q        <= '1;
                    r        <= a;
                    div_zero <= 1'b1;
                    done     <= 1'b1;
                end
            end else begin
                dvd <= dvd_nx;
                rem <= rem_nx;
                cnt <= cnt + 1'b1;
                if (cnt == CW'(N - 1)) begin
                    q     <= dvd_nx;
                    r     <= rem_nx;
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end
        end
    end
endmodule
